pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 49 ++++
 rtl/pipeline_ctrl_cnt.sv | 30 +++
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, stall
// vector patterns and bit positions, and redirect address constants.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MULTI = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      LVL_NONE = 3'd0,
      LVL_IF   = 3'd1,
      LVL_ID   = 3'd2,
      LVL_EX   = 3'd3,
      LVL_MEM  = 3'd4
   } stall_lvl_e;

   localparam int STALL_PC_BIT  = 5;
   localparam int STALL_IF_BIT  = 4;
   localparam int STALL_ID_BIT  = 3;
   localparam int STALL_EX_BIT  = 2;
   localparam int STALL_MEM_BIT = 1;
   localparam int STALL_WB_BIT  = 0;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b110000;
   localparam logic [5:0] STALL_ID   = 6'b111000;
   localparam logic [5:0] STALL_EX   = 6'b111100;
   localparam logic [5:0] STALL_MEM  = 6'b111110;

   localparam logic [15:0] ZERO16          = 16'h0000;
   localparam logic [15:0] EXC_VECTOR_DEF  = 16'h0004;
   localparam int          DIV_CYCLES_DEF  = 16;

   // Each level freezes its own stage and every stage upstream of it.
   function automatic logic [5:0] stall_vec(input stall_lvl_e lvl);
      logic [5:0] v;
      case (lvl)
         LVL_IF:  v = STALL_IF;
         LVL_ID:  v = STALL_ID;
         LVL_EX:  v = STALL_EX;
         LVL_MEM: v = STALL_MEM;
         default: v = STALL_NONE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_cnt.sv
// Loadable 6-bit down counter with freeze; tracks remaining cycles of a
// multi-cycle EX operation.
module pipeline_ctrl_cnt
   import pipeline_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [5:0] load_val,
   input  logic       dec,
   output logic [5:0] cnt
);

   // Clear dominates load, load dominates decrement; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 6'd0;
      end else if (clr) begin
         cnt <= 6'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - 6'd1;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: arbitrates stage stall requests,
// sequences multi-cycle EX ops and redirects the PC on exception/eret.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int          DIV_CYCLES = DIV_CYCLES_DEF,
   parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stallreq_if_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        multi_start_i,
   input  logic        excp_valid_i,
   input  logic [15:0] excp_pc_i,
   input  logic        eret_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [15:0] new_pc_o,
   output logic [15:0] epc_o,
   output logic        multi_done_o
);

   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

   state_e      state;
   state_e      state_next;
   stall_lvl_e  lvl;
   logic [15:0] epc;
   logic [5:0]  cnt;
   logic        cnt_clr;
   logic        cnt_load;
   logic        cnt_dec;
   logic        epc_we;
   logic        flush;
   logic        done;
   logic [15:0] new_pc;

   pipeline_ctrl_cnt u_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (DIV_LOAD),
      .dec      (cnt_dec),
      .cnt      (cnt)
   );

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Exception PC capture; only an exception writes it, eret only reads it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         epc <= ZERO16;
      end else if (epc_we) begin
         epc <= excp_pc_i;
      end else begin
         epc <= epc;
      end
   end

   // Next-state, stall arbitration, redirect and counter control.
   always_comb begin
      state_next = state;
      lvl        = LVL_NONE;
      flush      = 1'b0;
      new_pc     = ZERO16;
      done       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      epc_we     = 1'b0;

      case (state)
         ST_RUN, ST_MULTI: begin
            if (excp_valid_i) begin
               flush      = 1'b1;
               new_pc     = EXC_VECTOR;
               epc_we     = 1'b1;
               cnt_clr    = 1'b1;
               state_next = ST_DRAIN;
            end else if (eret_i) begin
               flush      = 1'b1;
               new_pc     = epc;
               cnt_clr    = 1'b1;
               state_next = ST_DRAIN;
            end else if (stallreq_mem_i) begin
               // Counter freezes; a pending start in RUN is not accepted yet.
               lvl = LVL_MEM;
            end else if (state == ST_MULTI) begin
               lvl     = LVL_EX;
               cnt_dec = 1'b1;
               if (cnt == 6'd1) begin
                  done       = 1'b1;
                  state_next = ST_RUN;
               end else begin
                  state_next = ST_MULTI;
               end
            end else if (multi_start_i) begin
               lvl        = LVL_EX;
               cnt_load   = 1'b1;
               state_next = ST_MULTI;
            end else if (stallreq_ex_i) begin
               lvl = LVL_EX;
            end else if (stallreq_id_i) begin
               lvl = LVL_ID;
            end else if (stallreq_if_i) begin
               lvl = LVL_IF;
            end else begin
               lvl = LVL_NONE;
            end
         end
         ST_DRAIN: begin
            state_next = ST_RUN;
         end
         default: begin
            cnt_clr    = 1'b1;
            state_next = ST_RUN;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of requests.
   always_comb begin
      if (rst_i) begin
         stall_o      = STALL_NONE;
         flush_o      = 1'b0;
         new_pc_o     = ZERO16;
         multi_done_o = 1'b0;
      end else begin
         stall_o      = stall_vec(lvl);
         flush_o      = flush;
         new_pc_o     = new_pc;
         multi_done_o = done;
      end
   end

   assign epc_o = epc;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (DIV_CYCLES=16,
// EXC_VECTOR=16'h0004); inputs change just after posedge, checks at negedge.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        multi_start;
   logic        excp_valid;
   logic [15:0] excp_pc;
   logic        eret;
   logic [5:0]  stall;
   logic        flush;
   logic [15:0] new_pc;
   logic [15:0] epc;
   logic        multi_done;

   int n_cmp;
   int n_err;

   pipeline_ctrl #(.DIV_CYCLES(16), .EXC_VECTOR(16'h0004)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .stallreq_if_i  (stallreq_if),
      .stallreq_id_i  (stallreq_id),
      .stallreq_ex_i  (stallreq_ex),
      .stallreq_mem_i (stallreq_mem),
      .multi_start_i  (multi_start),
      .excp_valid_i   (excp_valid),
      .excp_pc_i      (excp_pc),
      .eret_i         (eret),
      .stall_o        (stall),
      .flush_o        (flush),
      .new_pc_o       (new_pc),
      .epc_o          (epc),
      .multi_done_o   (multi_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      stallreq_if  = 1'b0;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      stallreq_mem = 1'b0;
      multi_start  = 1'b0;
      excp_valid   = 1'b0;
      excp_pc      = 16'h0000;
      eret         = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Pattern check of all redirect outputs in one go.
   task automatic check_outs(input string tag, input logic [5:0] e_stall, input logic e_flush,
                             input logic [15:0] e_pc, input logic e_done);
      check_val({tag, ".stall"}, 32'(stall), 32'(e_stall));
      check_val({tag, ".flush"}, 32'(flush), 32'(e_flush));
      check_val({tag, ".new_pc"}, 32'(new_pc), 32'(e_pc));
      check_val({tag, ".done"}, 32'(multi_done), 32'(e_done));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      rst = 1'b1;
      stallreq_id = 1'b1;
      #12;
      check_outs("reset", 6'b000000, 1'b0, 16'h0000, 1'b0);
      check_val("reset.epc", 32'(epc), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      next_cycle();

      // Priority among plain stall requests.
      stallreq_id = 1'b1;
      @(negedge clk); check_outs("id", 6'b111000, 1'b0, 16'h0000, 1'b0);
      next_cycle(); stallreq_mem = 1'b1;
      @(negedge clk); check_outs("id_mem", 6'b111110, 1'b0, 16'h0000, 1'b0);
      next_cycle(); idle_inputs(); stallreq_if = 1'b1;
      @(negedge clk); check_outs("if", 6'b110000, 1'b0, 16'h0000, 1'b0);
      next_cycle(); stallreq_ex = 1'b1; stallreq_id = 1'b1;
      @(negedge clk); check_outs("ex_id_if", 6'b111100, 1'b0, 16'h0000, 1'b0);
      next_cycle(); idle_inputs();
      @(negedge clk); check_outs("none", 6'b000000, 1'b0, 16'h0000, 1'b0);
      next_cycle();

      // Multi-cycle op, start held high throughout (must not restart).
      for (int k = 0; k <= 16; k++) begin
         multi_start = (k <= 15);
         @(negedge clk);
         check_outs($sformatf("multi_k%0d", k), (k <= 15) ? 6'b111100 : 6'b000000,
                    1'b0, 16'h0000, k == 15);
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // Mem stall for three cycles mid-op delays done to T+18.
      for (int k = 0; k <= 19; k++) begin
         multi_start  = (k == 0);
         stallreq_mem = (k >= 5 && k <= 7);
         @(negedge clk);
         check_outs($sformatf("memfrz_k%0d", k),
                    stallreq_mem ? 6'b111110 : ((k <= 18) ? 6'b111100 : 6'b000000),
                    1'b0, 16'h0000, k == 18);
         next_cycle();
      end
      idle_inputs();

      // Start blocked by a mem stall in RUN, accepted the following cycle.
      for (int k = 0; k <= 17; k++) begin
         multi_start  = (k <= 1);
         stallreq_mem = (k == 0);
         @(negedge clk);
         check_outs($sformatf("blocked_k%0d", k),
                    (k == 0) ? 6'b111110 : ((k <= 16) ? 6'b111100 : 6'b000000),
                    1'b0, 16'h0000, k == 16);
         next_cycle();
      end
      idle_inputs();

      // Exception during MULTI aborts the op; DRAIN ignores all requests.
      for (int k = 0; k <= 24; k++) begin
         idle_inputs();
         multi_start = (k == 0);
         if (k == 4) begin
            excp_valid = 1'b1;
            excp_pc    = 16'h0123;
         end else if (k == 5) begin
            excp_valid  = 1'b1;
            excp_pc     = 16'h0555;
            stallreq_id = 1'b1;
            multi_start = 1'b1;
            eret        = 1'b1;
         end else if (k == 6) begin
            stallreq_id = 1'b1;
         end else begin
            stallreq_id = 1'b0;
         end
         @(negedge clk);
         if (k == 4) begin
            check_outs("excp_flush", 6'b000000, 1'b1, 16'h0004, 1'b0);
         end else if (k == 5) begin
            check_outs("excp_drain", 6'b000000, 1'b0, 16'h0000, 1'b0);
            check_val("excp_epc", 32'(epc), 32'h0123);
         end else if (k == 6) begin
            check_outs("excp_run", 6'b111000, 1'b0, 16'h0000, 1'b0);
            check_val("excp_epc_kept", 32'(epc), 32'h0123);
         end else if (k > 6) begin
            check_val($sformatf("excp_nodone_k%0d", k), 32'(multi_done), 32'h0);
         end else begin
            check_outs($sformatf("excp_pre_k%0d", k), 6'b111100, 1'b0, 16'h0000, 1'b0);
         end
         next_cycle();
      end
      idle_inputs();

      // Eret redirects to saved PC and overrides a concurrent mem stall.
      eret = 1'b1; stallreq_mem = 1'b1;
      @(negedge clk); check_outs("eret", 6'b000000, 1'b1, 16'h0123, 1'b0);
      next_cycle(); idle_inputs(); stallreq_ex = 1'b1;
      @(negedge clk); check_outs("eret_drain", 6'b000000, 1'b0, 16'h0000, 1'b0);
      check_val("eret_epc", 32'(epc), 32'h0123);
      next_cycle();
      @(negedge clk); check_outs("eret_run", 6'b111100, 1'b0, 16'h0000, 1'b0);
      next_cycle(); idle_inputs();

      // Exception and eret together: exception wins.
      excp_valid = 1'b1; eret = 1'b1; excp_pc = 16'h0abc;
      @(negedge clk); check_outs("excp_eret", 6'b000000, 1'b1, 16'h0004, 1'b0);
      next_cycle(); idle_inputs();
      @(negedge clk); check_val("excp_eret_epc", 32'(epc), 32'h0abc);
      check_val("excp_eret_drain", 32'(flush), 32'h0);
      next_cycle(); next_cycle();

      // Reset between edges mid-MULTI.
      multi_start = 1'b1;
      next_cycle(); multi_start = 1'b0;
      next_cycle(); next_cycle();
      #2;
      rst = 1'b1;
      #1;
      check_outs("rst_mid", 6'b000000, 1'b0, 16'h0000, 1'b0);
      check_val("rst_mid.epc", 32'(epc), 32'h0);
      next_cycle(); next_cycle();
      #2;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         @(negedge clk);
         check_outs($sformatf("post_rst_k%0d", k), 6'b000000, 1'b0, 16'h0000, 1'b0);
      end
      next_cycle();
      stallreq_id = 1'b1;
      @(negedge clk); check_outs("post_rst_run", 6'b111000, 1'b0, 16'h0000, 1'b0);
      next_cycle();
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
